// File: rtl/dly_scan_seq_pkg.sv
// Shared definitions for the delay-scan sequencer.
//   scan_state_t     : sequencer FSM states
//   DEF_DLY_WIDTH    : default delay tap width
//   DEF_SAMPLE_LOG2  : default log2 of the sample window length
package dly_scan_pkg;

  localparam int unsigned DEF_DLY_WIDTH   = 5;
  localparam int unsigned DEF_SAMPLE_LOG2 = 6;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    LOAD,
    SET,
    SETTLE,
    SAMPLE,
    REPORT,
    DONE
  } scan_state_t;

endpackage

// File: rtl/dly_scan_seq_if.sv
// Result channel of the delay-scan sequencer (valid/ready handshake).
//   res_valid : result available (driven by the sequencer)
//   res_ready : consumer accepts the result
//   res_delay : tap the result belongs to
//   res_count : number of high samples in the window (0..2**SAMPLE_LOG2)
// Modports: master = sequencer side, slave = consumer side.
interface dly_scan_seq_if
  import dly_scan_pkg::*;
#(
  parameter int unsigned DLY_WIDTH   = DEF_DLY_WIDTH,
  parameter int unsigned SAMPLE_LOG2 = DEF_SAMPLE_LOG2
);

  logic                 res_valid;
  logic                 res_ready;
  logic [DLY_WIDTH-1:0] res_delay;
  logic [SAMPLE_LOG2:0] res_count;

  modport master (
    output res_valid,
    output res_delay,
    output res_count,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_delay,
    input  res_count,
    output res_ready
  );

endinterface

// File: rtl/dly_scan_seq_sync_bit.sv
// Single-bit synchronizer for asynchronous inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears all stages
//   d     : asynchronous input
//   q     : synchronized output, SYNC_STAGES cycles behind d
module sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/dly_scan_seq.sv
// Delay-scan sequencer for DQS/DQ timing calibration (clk_div domain).
// For each tap first, first+step, ... <= last it loads and applies the delay,
// waits SETTLE_CYCLES, counts high dqs_received samples over 2**SAMPLE_LOG2
// cycles and reports (tap, count) on the result channel.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, abort        : scan start pulse / level abort (abort wins)
//   dly_first/last/step : scan range, captured on an accepted start
//   dly_ready           : delay-controller ready (async)
//   dqs_received        : received strobe (async)
//   dly_data, ld, set   : delay value and load/apply strobes to the delay pipe
//   res                 : result channel (master side)
//   busy, done, err     : scan running / completed / range error on last start
module dly_scan_seq
  import dly_scan_pkg::*;
#(
  parameter int unsigned DLY_WIDTH     = DEF_DLY_WIDTH,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned SAMPLE_LOG2   = DEF_SAMPLE_LOG2,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DLY_WIDTH-1:0] dly_first,
  input  logic [DLY_WIDTH-1:0] dly_last,
  input  logic [DLY_WIDTH-1:0] dly_step,
  input  logic                 dly_ready,
  input  logic                 dqs_received,
  output logic [DLY_WIDTH-1:0] dly_data,
  output logic                 ld,
  output logic                 set,
  dly_scan_seq_if.master       res,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned SAMPLE_LEN = 2 ** SAMPLE_LOG2;
  localparam int unsigned TMR_MAX    = (SETTLE_CYCLES > SAMPLE_LEN) ? SETTLE_CYCLES : SAMPLE_LEN;
  localparam int unsigned TW         = $clog2(TMR_MAX + 1);
  localparam logic [TW-1:0] SETTLE_END = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] SAMPLE_END = TW'(SAMPLE_LEN - 1);

  scan_state_t            state, state_nx;
  logic [DLY_WIDTH-1:0]   cur, cur_nx;
  logic [DLY_WIDTH-1:0]   last_q, step_q;
  logic [TW-1:0]          tmr, tmr_nx;
  logic [SAMPLE_LOG2:0]   acc, acc_nx;
  logic [DLY_WIDTH:0]     sum;
  logic                   rdy_s, dqs_s;
  logic                   start_ok, range_bad;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rdy (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dly_ready),
    .q     (rdy_s)
  );

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dqs (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dqs_received),
    .q     (dqs_s)
  );

  // Extra carry bit so that a step past the top tap ends the scan instead of wrapping.
  assign sum       = {1'b0, cur} + {1'b0, step_q};
  assign range_bad = (dly_step == '0) || (dly_first > dly_last);
  assign start_ok  = start && !abort && ((state == IDLE) || (state == DONE));
  assign busy      = (state != IDLE) && (state != DONE);

  always_comb begin
    state_nx = state;
    cur_nx   = cur;
    tmr_nx   = tmr;
    acc_nx   = acc;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (range_bad) begin
              state_nx = IDLE;
            end else begin
              state_nx = WAIT_RDY;
              cur_nx   = dly_first;
            end
          end
        end
        WAIT_RDY: begin
          if (rdy_s) state_nx = LOAD;
        end
        LOAD: state_nx = SET;
        SET: begin
          state_nx = SETTLE;
          tmr_nx   = '0;
        end
        SETTLE: begin
          if (!rdy_s) begin
            state_nx = WAIT_RDY;
          end else if (tmr == SETTLE_END) begin
            state_nx = SAMPLE;
            tmr_nx   = '0;
            acc_nx   = '0;
          end else begin
            tmr_nx = tmr + 1'b1;
          end
        end
        SAMPLE: begin
          acc_nx = acc + {{SAMPLE_LOG2{1'b0}}, dqs_s};
          if (!rdy_s) begin
            // Partial window is discarded; the same tap is re-run from LOAD.
            state_nx = WAIT_RDY;
          end else if (tmr == SAMPLE_END) begin
            state_nx = REPORT;
          end else begin
            tmr_nx = tmr + 1'b1;
          end
        end
        REPORT: begin
          if (res.res_valid && res.res_ready) begin
            if (sum > {1'b0, last_q}) begin
              state_nx = DONE;
            end else begin
              cur_nx   = sum[DLY_WIDTH-1:0];
              // Next tap goes straight to LOAD; dly_ready is not re-checked.
              state_nx = LOAD;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Strobes and result outputs are registered from the next state, so each one
  // is high exactly while the FSM sits in the matching state and drops together
  // with an abort-forced transition to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cur           <= '0;
      last_q        <= '0;
      step_q        <= '0;
      tmr           <= '0;
      acc           <= '0;
      dly_data      <= '0;
      ld            <= 1'b0;
      set           <= 1'b0;
      res.res_valid <= 1'b0;
      res.res_delay <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_nx;
      cur           <= cur_nx;
      tmr           <= tmr_nx;
      acc           <= acc_nx;
      ld            <= (state_nx == LOAD);
      set           <= (state_nx == SET);
      res.res_valid <= (state_nx == REPORT);
      if (state_nx == LOAD) dly_data <= cur_nx;
      if (state_nx == REPORT) res.res_delay <= cur_nx;
      if (start_ok) begin
        last_q <= dly_last;
        step_q <= dly_step;
        done   <= 1'b0;
        err    <= range_bad;
      end else if ((state == REPORT) && (state_nx == DONE)) begin
        done <= 1'b1;
      end
    end
  end

  // The accumulator is cleared on entry to SAMPLE and frozen afterwards, so it
  // holds the finished count throughout REPORT.
  assign res.res_count = acc;

endmodule

// File: tb/tb_dly_scan_seq.sv
module tb_dly_scan_seq;

  localparam int W  = 5;
  localparam int S  = 8;
  localparam int L2 = 6;
  localparam int N  = 1 << L2;

  logic         clk          = 1'b0;
  logic         rst_n        = 1'b0;
  logic         start        = 1'b0;
  logic         abort        = 1'b0;
  logic [W-1:0] dly_first    = '0;
  logic [W-1:0] dly_last     = '0;
  logic [W-1:0] dly_step     = '0;
  logic         dly_ready    = 1'b0;
  logic         dqs_received = 1'b0;
  logic [W-1:0] dly_data;
  logic         ld, set, busy, done, err;

  dly_scan_seq_if #(.DLY_WIDTH(W), .SAMPLE_LOG2(L2)) res_if ();

  dly_scan_seq #(
    .DLY_WIDTH     (W),
    .SETTLE_CYCLES (S),
    .SAMPLE_LOG2   (L2),
    .SYNC_STAGES   (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .dly_first    (dly_first),
    .dly_last     (dly_last),
    .dly_step     (dly_step),
    .dly_ready    (dly_ready),
    .dqs_received (dqs_received),
    .dly_data     (dly_data),
    .ld           (ld),
    .set          (set),
    .res          (res_if),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state: the taps the current scan must visit, in order.
  int taps[$];
  int idx = 0;
  int got_dly[$];
  int got_cnt[$];
  int ld_cnt = 0, set_cnt = 0;
  int set_cyc = 0, start_cyc = 0;
  int first_ld_cyc = -1, first_set_cyc = -1, first_val_cyc = -1;
  int exp_done_cyc = -1;
  bit hist[int];

  int dqs_mode = 1;  // 0 low, 1 high, 2 toggle, 3 random
  int rr_mode  = 1;  // 0 never ready, 1 always ready, 2 random

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Sampling starts S+1 cycles after the set cycle and lasts N cycles; the
  // two-stage synchronizer means those samples are the raw values two cycles earlier.
  function automatic int window_sum(input int s);
    int sum = 0;
    for (int k = s + S - 1; k <= s + S + N - 2; k++)
      if (hist.exists(k)) sum += int'(hist[k]);
    return sum;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Input drivers for the strobe line and the consumer.
  initial begin
    res_if.res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (dqs_mode)
        0:       dqs_received = 1'b0;
        1:       dqs_received = 1'b1;
        2:       dqs_received = ~dqs_received;
        default: dqs_received = 1'($urandom_range(0, 1));
      endcase
      case (rr_mode)
        0:       res_if.res_ready = 1'b0;
        1:       res_if.res_ready = 1'b1;
        default: res_if.res_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Per-cycle compare process.
  initial begin
    bit       prev_ld = 0, prev_valid = 0, prev_ready = 0, prev_abort = 0;
    int       prev_dly = 0, prev_rdly = 0, prev_rcnt = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        hist[cyc] = dqs_received;
        check("ld_set_exclusive", int'(ld & set), 0);
        if (!ld) check("dly_data_hold", int'(dly_data), prev_dly);
        if (ld) begin
          ld_cnt++;
          if (first_ld_cyc < 0) first_ld_cyc = cyc;
          if (idx < taps.size()) check("ld_tap", int'(dly_data), taps[idx]);
          else check("ld_unexpected", 1, 0);
        end
        if (set) begin
          set_cnt++;
          if (first_set_cyc < 0) first_set_cyc = cyc;
          check("set_after_ld", int'(prev_ld), 1);
          set_cyc = cyc;
        end
        if (res_if.res_valid && !prev_valid) begin
          if (first_val_cyc < 0) first_val_cyc = cyc;
          check("valid_latency", cyc, set_cyc + S + N + 1);
          if (idx < taps.size()) check("res_delay", int'(res_if.res_delay), taps[idx]);
          else check("valid_unexpected", 1, 0);
          check("res_count", int'(res_if.res_count), window_sum(set_cyc));
        end
        if (prev_valid && !prev_ready && !prev_abort) begin
          check("valid_hold", int'(res_if.res_valid), 1);
          check("delay_hold", int'(res_if.res_delay), prev_rdly);
          check("count_hold", int'(res_if.res_count), prev_rcnt);
        end
        if (res_if.res_valid && res_if.res_ready) begin
          got_dly.push_back(int'(res_if.res_delay));
          got_cnt.push_back(int'(res_if.res_count));
          idx++;
          if (idx == taps.size()) exp_done_cyc = cyc + 1;
        end
        if (cyc == exp_done_cyc) begin
          check("done_after_last", int'(done), 1);
          check("idle_after_last", int'(busy), 0);
          exp_done_cyc = -1;
        end
      end
      prev_ld    = ld;
      prev_dly   = int'(dly_data);
      prev_valid = res_if.res_valid;
      prev_ready = res_if.res_ready;
      prev_abort = abort;
      prev_rdly  = int'(res_if.res_delay);
      prev_rcnt  = int'(res_if.res_count);
    end
  end

  task automatic do_start(input int f, input int l, input int s);
    bit ok;
    ok        = (s != 0) && (f <= l);
    dly_first = W'(f);
    dly_last  = W'(l);
    dly_step  = W'(s);
    start     = 1'b1;
    taps.delete();
    got_dly.delete();
    got_cnt.delete();
    idx = 0; ld_cnt = 0; set_cnt = 0;
    first_ld_cyc = -1; first_set_cyc = -1; first_val_cyc = -1;
    if (ok) for (int t = f; t <= l; t += s) taps.push_back(t);
    start_cyc = cyc;
    step(1);
    start = 1'b0;
    check("start_err", int'(err), ok ? 0 : 1);
    check("start_busy", int'(busy), ok ? 1 : 0);
    check("start_done_clr", int'(done), 0);
  endtask

  task automatic wait_done(input int max_cyc);
    int i = 0;
    while (!done && i < max_cyc) begin
      step(1);
      i++;
    end
    check("scan_finished", int'(done), 1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values
    step(2);
    check("rst_outputs", int'({ld, set, res_if.res_valid, busy, done, err}), 0);
    check("rst_dly_data", int'(dly_data), 0);
    check("rst_res_delay", int'(res_if.res_delay), 0);
    check("rst_res_count", int'(res_if.res_count), 0);
    rst_n     = 1'b1;
    dly_ready = 1'b1;
    step(4);

    // 1: full-high window, three points; a start while busy must be ignored
    dqs_mode = 1; rr_mode = 1;
    do_start(0, 4, 2);
    step(30);
    dly_first = 5'd9; dly_last = 5'd20; dly_step = 5'd1; start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done(1000);
    check("t1_npoints", got_dly.size(), 3);
    check("t1_d0", got_dly[0], 0);
    check("t1_d1", got_dly[1], 2);
    check("t1_d2", got_dly[2], 4);
    check("t1_c0", got_cnt[0], 64);
    check("t1_c2", got_cnt[2], 64);
    check("t1_ld_pulses", ld_cnt, 3);
    check("t1_set_pulses", set_cnt, 3);
    check("t1_busy", int'(busy), 0);

    // 2: toggling strobe, single point, latency
    dqs_mode = 2;
    do_start(7, 7, 1);
    wait_done(500);
    check("t2_npoints", got_dly.size(), 1);
    check("t2_delay", got_dly[0], 7);
    check("t2_count_near_half", int'(got_cnt[0] >= 31 && got_cnt[0] <= 33), 1);
    check("t2_ld_cycle", first_ld_cyc - start_cyc, 2);
    check("t2_set_cycle", first_set_cyc - start_cyc, 3);
    check("t2_valid_cycle", first_val_cyc - start_cyc, 76);

    // 3: step past the top tap ends the scan, all-low window
    dqs_mode = 0;
    do_start(30, 31, 3);
    wait_done(500);
    check("t3_npoints", got_dly.size(), 1);
    check("t3_delay", got_dly[0], 30);
    check("t3_count_zero", got_cnt[0], 0);

    // 4: range errors, then a valid start clears err
    do_start(3, 5, 0);
    step(20);
    check("t4_no_ld", ld_cnt + set_cnt, 0);
    check("t4_err_held", int'(err), 1);
    check("t4_busy", int'(busy), 0);
    do_start(5, 3, 1);
    step(20);
    check("t4b_no_ld", ld_cnt + set_cnt, 0);
    check("t4b_err_held", int'(err), 1);
    dqs_mode = 3;
    do_start(1, 1, 1);
    wait_done(500);

    // 5: dly_ready drop mid-SAMPLE re-runs the same tap with a fresh window
    do_start(2, 2, 1);
    begin
      int i = 0;
      while (set_cnt == 0 && i < 100) begin step(1); i++; end
      check("t5_first_set", set_cnt, 1);
    end
    step(set_cyc + S + 20 - cyc);
    dly_ready = 1'b0;
    step(10);
    check("t5_waiting_no_valid", int'(res_if.res_valid), 0);
    check("t5_waiting_busy", int'(busy), 1);
    dly_ready = 1'b1;
    wait_done(500);
    check("t5_ld_pulses", ld_cnt, 2);
    check("t5_set_pulses", set_cnt, 2);
    check("t5_npoints", got_dly.size(), 1);
    check("t5_delay", got_dly[0], 2);

    // 6: back-pressure holds the result, then abort from REPORT
    rr_mode = 0;
    do_start(3, 10, 4);
    begin
      int i = 0;
      while (!res_if.res_valid && i < 200) begin step(1); i++; end
      check("t6_valid_seen", int'(res_if.res_valid), 1);
    end
    step(10);
    check("t6_valid_held", int'(res_if.res_valid), 1);
    check("t6_delay_held", int'(res_if.res_delay), 3);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("t6_abort_valid", int'(res_if.res_valid), 0);
    check("t6_abort_busy", int'(busy), 0);
    check("t6_abort_done", int'(done), 0);
    taps.delete();
    idx = 0;
    step(100);
    check("t6_no_more_results", got_dly.size(), 0);

    // Randomized scans with random back-pressure and strobe
    rr_mode = 2; dqs_mode = 3;
    for (int it = 0; it < 10; it++) begin
      int f, l, s;
      f = int'($urandom_range(0, 31));
      s = int'($urandom_range(1, 8));
      l = f + int'($urandom_range(0, 5 * s));
      if (l > 31) l = 31;
      if (it % 4 == 3) begin
        if (f == 0 || $urandom_range(0, 1) == 0) s = 0;
        else l = f - 1;
      end
      do_start(f, l, s);
      if (taps.size() > 0) begin
        wait_done(4000);
        check("rand_npoints", got_dly.size(), taps.size());
      end else begin
        step(10);
        check("rand_err_no_ld", ld_cnt, 0);
      end
    end

    step(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dly_scan_seq.md
Name: dly_scan_seq

Overview:
- Delay-scan sequencer for DQS/DQ timing calibration.
- Sits directly upstream of the DQS test/PHY stage. Drives its delay value with the ld/set strobes, and consumes its dqs_received return.
- For each tap in a programmed range it loads and applies the delay, lets the line settle, then counts high samples of dqs_received over a fixed window. Each (delay, count) result is reported over a valid/ready handshake.
- Runs in the clk_div (serializer parallel clock) domain.

Parameters:
DLY_WIDTH, 5, width of the delay tap value (dly_data, range inputs, res_delay)
SETTLE_CYCLES, 8, clk cycles waited after set before sampling (min 1)
SAMPLE_LOG2, 6, sample window length = 2**SAMPLE_LOG2 cycles
SYNC_STAGES, 2, flip-flop stages on the asynchronous inputs dly_ready and dqs_received (min 2)

Ports:
clk  input  1  sequencer clock (clk_div domain); all logic rising-edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse, begins a scan; ignored while busy=1
abort  input  1  level; forces IDLE from any state
dly_first  input  DLY_WIDTH  first tap of scan, sampled on accepted start
dly_last  input  DLY_WIDTH  last tap of scan, sampled on accepted start
dly_step  input  DLY_WIDTH  tap increment, sampled on accepted start
dly_ready  input  1  delay-controller ready (async, synchronized inside)
dqs_received  input  1  received strobe/data (async, synchronized inside)
dly_data  output  DLY_WIDTH  delay value presented to the delay pipe
ld  output  1  one-cycle load strobe to the delay pipe
set  output  1  one-cycle apply strobe to the delay pipe
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_delay  output  DLY_WIDTH  tap the result belongs to
res_count  output  SAMPLE_LOG2+1  number of high samples in window (0..2**SAMPLE_LOG2)
busy  output  1  scan in progress (state != IDLE and != DONE)
done  output  1  scan completed normally; held until next accepted start
err  output  1  range error on last start; held until next accepted start

Behaviour:
- Reset values: dly_data=0, ld=0, set=0, res_valid=0, res_delay=0, res_count=0, busy=0, done=0, err=0; state=IDLE; synchronizers cleared.
- States and transitions:
  - IDLE/DONE: on start, latch range, clear done/err. If step==0 or first>last: set err, go to IDLE. Otherwise cur=first and go to WAIT_RDY.
  - WAIT_RDY: while synchronized dly_ready=1, go to LOAD.
  - LOAD: dly_data=cur, ld=1 for exactly this cycle; go to SET.
  - SET: set=1 for exactly this cycle; go to SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles, then go to SAMPLE.
  - SAMPLE: for exactly 2**SAMPLE_LOG2 cycles, add the synchronized dqs_received to the count; then go to REPORT.
  - REPORT: res_valid=1 with res_delay=cur and res_count held stable. On res_valid&&res_ready: drop res_valid, compute next=cur+step in DLY_WIDTH+1 bits. If next>last, go to DONE (done=1). Otherwise cur=next and go to LOAD (dly_ready is not re-checked).
- dly_data changes only in LOAD and is held through REPORT. ld and set are never high in the same cycle.
- Latency, with dly_ready already synchronized high:
  - start at cycle 0 → ld at cycle 2, set at cycle 3.
  - Sampling begins at cycle 4+SETTLE_CYCLES.
  - res_valid first rises at cycle 4+SETTLE_CYCLES+2**SAMPLE_LOG2.
- Wrap-around: the step sum carries into the extra bit, so a scan never wraps past 2**DLY_WIDTH-1. first=last gives exactly one point.
- dly_ready dropping (synchronized) in SETTLE or SAMPLE: discard the partial count and return to WAIT_RDY. The same cur is re-run from LOAD.
- abort=1: next state IDLE, even during REPORT. ld, set and res_valid are forced to 0 in the same cycle the state changes. done and err are unchanged. abort has priority over start in the same cycle.
- start while busy is ignored. start in the same cycle as abort is ignored.
- res_count width guarantees no overflow: an all-high window gives 2**SAMPLE_LOG2.

Decomposition:
- Shared package dly_scan_pkg holds:
  - state encoding constants: IDLE, WAIT_RDY, LOAD, SET, SETTLE, SAMPLE, REPORT, DONE;
  - default DLY_WIDTH and SAMPLE_LOG2.
- One sub-module, sync_bit: a SYNC_STAGES-deep async-reset (rst_n) synchronizer. It is instantiated twice, for dly_ready and dqs_received.

Test Plan:
1. dly_ready=1, dqs_received=1, first=0, last=4, step=2, res_ready=1 → three results (0,64), (2,64), (4,64); exactly three ld and three set pulses; then done=1, busy=0.
2. dqs_received toggling every cycle, first=last=7 → one result with delay 7 and count 32±1; ld at cycle 2, set at cycle 3, res_valid at cycle 76 (defaults).
3. first=30, last=31, step=3 → a single result at delay 30, then done; no wrap to tap 1.
4. step=0 or first=5, last=3 → err=1, no ld/set pulses, busy stays 0; a following valid start clears err.
5. dly_ready dropped mid-SAMPLE at delay 2 → sequencer waits; after dly_ready returns, ld/set re-pulse at delay 2; the reported count covers only the fresh window.
6. res_ready held 0 for 10 cycles in REPORT → res_valid, res_delay and res_count stable. Then assert abort → res_valid=0 the next cycle, state IDLE, done=0.
